exec_unit: RTL

//  8-bit execute stage that sits directly downstream of the register file.
//  - Consumes the two register-file read operands and a 3-bit opcode.
//  - Most ops complete in one cycle; shifts are iterative, one bit per cycle.
//  - Produces a registered write-back triple (WbEn/WbAddr/WbData) that feeds
//    the register-file write port, plus registered Zero/Carry flags.

---
 rtl/exec_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// Execute stage between register-file read and write ports: single-cycle ALU ops
// plus iterative one-bit-per-cycle shifts, producing a registered write-back triple and flags.
module exec_unit #(
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         InValid,
    output logic         InReady,
    input  logic [2:0]   Op,
    input  logic [W-1:0] OperandA,
    input  logic [W-1:0] OperandB,
    input  logic [A-1:0] DestAddr,
    input  logic         Flush,
    output logic         WbEn,
    output logic [A-1:0] WbAddr,
    output logic [W-1:0] WbData,
    output logic         Zero,
    output logic         Carry,
    output logic         Busy,
    output logic         DbgState
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_PAR = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t       state_q;
    logic [W-1:0] acc_q;
    logic [2:0]   count_q;
    logic [A-1:0] dest_q;
    logic         dir_q;
    logic         wb_en_q;
    logic [A-1:0] wb_addr_q;
    logic [W-1:0] wb_data_q;
    logic         zero_q;
    logic         carry_q;

    logic         accept;
    logic         shift_req;
    logic [W-1:0] alu_data_d;
    logic         alu_carry_d;
    logic [W-1:0] step_acc_d;
    logic         step_out_d;

    // Handshake: a request is taken at a rising edge where InValid & InReady; the
    // upstream stage holds Op/operands/DestAddr until then. InValid is ignored in SHIFT.
    assign InReady   = Reset_n & (state_q == IDLE) & ~Flush;
    assign accept    = InValid & InReady;
    assign shift_req = ((Op == OP_SHL) || (Op == OP_SHR)) && (OperandB[2:0] != 3'd0);

    always_comb begin
        alu_data_d  = '0;
        alu_carry_d = 1'b0;
        case (Op)
            OP_ADD: {alu_carry_d, alu_data_d} = {1'b0, OperandA} + {1'b0, OperandB};
            OP_SUB: begin
                alu_data_d  = OperandA - OperandB;
                alu_carry_d = (OperandA < OperandB);
            end
            OP_AND: alu_data_d = OperandA & OperandB;
            OP_XOR: alu_data_d = OperandA ^ OperandB;
            OP_PAR: alu_data_d = {{(W-1){1'b0}}, ^OperandA};
            OP_MOV, OP_SHL, OP_SHR: alu_data_d = OperandA;
            default: alu_data_d = '0;
        endcase
    end

    // dir_q=1 shifts right; the bit falling off the end becomes the candidate carry.
    always_comb begin
        step_acc_d = dir_q ? {1'b0, acc_q[W-1:1]} : {acc_q[W-2:0], 1'b0};
        step_out_d = dir_q ? acc_q[0] : acc_q[W-1];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            dest_q    <= '0;
            dir_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (shift_req) begin
                            acc_q   <= OperandA;
                            count_q <= OperandB[2:0];
                            dest_q  <= DestAddr;
                            dir_q   <= Op[0];
                            state_q <= SHIFT;
                        end else begin
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= DestAddr;
                            wb_data_q <= alu_data_d;
                            zero_q    <= (alu_data_d == '0);
                            carry_q   <= alu_carry_d;
                        end
                    end
                end
                SHIFT: begin
                    if (Flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q   <= step_acc_d;
                        count_q <= count_q - 3'd1;
                        // Last step writes back and frees the unit on the same edge.
                        if (count_q == 3'd1) begin
                            wb_en_q   <= 1'b1;
                            wb_addr_q <= dest_q;
                            wb_data_q <= step_acc_d;
                            zero_q    <= (step_acc_d == '0);
                            carry_q   <= step_out_d;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign WbEn     = wb_en_q;
    assign WbAddr   = wb_addr_q;
    assign WbData   = wb_data_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Busy     = (state_q == SHIFT);
    assign DbgState = state_q;

endmodule
